// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Initiator side of the CPU-to-data-memory interface. Accepts
//                byte/half/word load/store requests over valid/ready and
//                drives a word-only memory port. Sub-word stores are done as
//                read-modify-write; loads are lane-selected and sign/zero
//                extended. Misaligned or out-of-range requests return an
//                error response without touching memory.
//  Ports       : clk, rst (sync, active-low)
//                req_valid/req_ready/req_op/req_addr/req_wdata  - request
//                resp_valid/resp_ready/resp_rdata/resp_err      - response
//                mem_read/mem_write/mem_addr/mem_wdata/mem_rdata - memory
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0]  c_OP_LB  = 3'd0;
    localparam logic [2:0]  c_OP_LH  = 3'd1;
    localparam logic [2:0]  c_OP_LW  = 3'd2;
    localparam logic [2:0]  c_OP_LBU = 3'd3;
    localparam logic [2:0]  c_OP_LHU = 3'd4;
    localparam logic [2:0]  c_OP_SB  = 3'd5;
    localparam logic [2:0]  c_OP_SH  = 3'd6;
    localparam logic [2:0]  c_OP_SW  = 3'd7;
    localparam logic [31:0] c_MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;   // store data; becomes the merged word for SB/SH
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] w_req_word;
    logic        w_misaligned;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_sub_store;

    assign w_req_word = {req_addr[31:2], 2'b00};

    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            c_OP_LH, c_OP_LHU, c_OP_SH: w_misaligned = req_addr[0];
            c_OP_LW, c_OP_SW:           w_misaligned = |req_addr[1:0];
            default:                    w_misaligned = 1'b0;
        endcase
    end

    assign w_req_err   = w_misaligned || (w_req_word > c_MAX_ADDR);
    assign w_sub_store = (r_op == c_OP_SB) || (r_op == c_OP_SH);

    // Lane selection and extension of the word returned in READ.
    always_comb begin
        w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load = 32'd0;
        case (r_op)
            c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {24'd0, w_byte};
            c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load = {16'd0, w_half};
            c_OP_LW:  w_load = mem_rdata;
            default:  w_load = 32'd0;
        endcase
    end

    // Read-modify-write merge of store data into the word just read.
    always_comb begin
        w_merged = mem_rdata;
        if (r_op == c_OP_SB) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_op == c_OP_SH) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)              w_next = S_RESP;
                    else if (req_op == c_OP_SW) w_next = S_WRITE;
                    else                        w_next = S_READ;
                end
            end
            S_READ:  w_next = w_sub_store ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= 32'd0;
                        r_err   <= w_req_err;
                    end
                end
                S_READ: begin
                    if (w_sub_store) r_wdata <= w_merged;
                    else             r_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    // Reset gates every strobe combinationally so an abandoned WRITE never lands.
    assign req_ready  = rst && (r_state == S_IDLE);
    assign mem_read   = rst && (r_state == S_READ);
    assign mem_write  = rst && (r_state == S_WRITE);
    assign mem_addr   = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = mem_write ? r_wdata : 32'd0;
    assign resp_valid = rst && (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

`default_nettype wire
